// File: rtl/qspi_flash_read_controller.sv
// ---------------------------------------------------------------------------
// qspi_flash_read_controller
// Read-only quad-SPI NOR flash controller for the cartridge ROM path. Issues
// Fast Read Quad I/O (0xEB) at a start address, then streams sequential data
// words until stopped. A host stall freezes SCK low between words.
//
// Ports:
//   clk, rstn          system clock, synchronous active-low reset
//   spi_data_in[3:0]   IO[3:0] from flash (IO0 = bit 0)
//   spi_data_out[3:0]  IO[3:0] drive values
//   spi_data_oe[3:0]   per-bit output enable, 1 = drive
//   spi_select         chip select, active low
//   spi_clk_out        SCK, period = 2 clk
//   addr_in            start byte address, sampled with start_read
//   start_read         begin a transaction (ignored unless idle)
//   stall_read         hold the stream once the current word is complete
//   stop_read          end the transaction
//   data_out           last completed word, first byte in bits [7:0]
//   data_ready         data_out holds a complete word
//   busy               transaction in progress (select asserted)
// ---------------------------------------------------------------------------
module qspi_flash_read_controller #(
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int ADDR_BITS        = 24
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [3:0]                    spi_data_in,
  output logic [3:0]                    spi_data_out,
  output logic [3:0]                    spi_data_oe,
  output logic                          spi_select,
  output logic                          spi_clk_out,
  input  logic [ADDR_BITS-1:0]          addr_in,
  input  logic                          start_read,
  input  logic                          stall_read,
  input  logic                          stop_read,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          data_ready,
  output logic                          busy
);

  localparam int WORD_W       = 8 * DATA_WIDTH_BYTES;
  localparam int NIB_PER_WORD = 2 * DATA_WIDTH_BYTES;
  localparam int CNT_W        = 8;

  localparam logic [7:0]       CMD_QUAD_READ = 8'hEB;
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMD_LAST      = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST     = CNT_W'(ADDR_BITS / 4 - 1);
  localparam logic [CNT_W-1:0] MODE_LAST     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DUMMY_LAST    = CNT_W'(3);
  localparam logic [CNT_W-1:0] WORD_LAST     = CNT_W'(NIB_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA
  } state_t;

  state_t               r_state;
  logic                 r_start_pend;
  logic [ADDR_BITS-1:0] r_addr;
  logic [7:0]           r_cmd;
  logic [CNT_W-1:0]     r_cnt;
  logic [WORD_W-1:0]    r_acc;
  logic [WORD_W-1:0]    r_data;
  logic [3:0]           r_io_out;
  logic [3:0]           r_io_oe;
  logic                 r_sel;
  logic                 r_sck;
  logic                 r_busy;
  logic                 r_ready;

  logic [CNT_W-1:0]     w_nib_pos;
  logic [WORD_W-1:0]    w_acc_next;
  logic                 w_hold;

  // Nibble k of a word lands at position k^1: high nibble of each byte first.
  assign w_nib_pos = r_cnt ^ CNT_ONE;
  // Stall only bites once a word is on data_out; it gates the next SCK rise.
  assign w_hold    = stall_read && r_ready;

  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < NIB_PER_WORD; i++) begin
      if (w_nib_pos == CNT_W'(i)) w_acc_next[i*4 +: 4] = spi_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_start_pend <= 1'b0;
      r_addr       <= '0;
      r_cmd        <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_data       <= '0;
      r_io_out     <= 4'h0;
      r_io_oe      <= 4'h0;
      r_sel        <= 1'b1;
      r_sck        <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
    end else if (r_busy && stop_read) begin
      // Stop beats stall and any concurrent start; data_out is kept.
      r_state  <= S_IDLE;
      r_io_out <= 4'h0;
      r_io_oe  <= 4'h0;
      r_sel    <= 1'b1;
      r_sck    <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_start_pend) begin
            // Select asserts one cycle after the start edge; first command
            // bit is already on IO0 for the first SCK rise.
            r_start_pend <= 1'b0;
            r_state      <= S_CMD;
            r_sel        <= 1'b0;
            r_busy       <= 1'b1;
            r_sck        <= 1'b0;
            r_cnt        <= '0;
            r_io_oe      <= 4'b0001;
            r_io_out     <= {3'b000, CMD_QUAD_READ[7]};
            r_cmd        <= {CMD_QUAD_READ[6:0], 1'b0};
          end else if (start_read) begin
            r_start_pend <= 1'b1;
            r_addr       <= addr_in;
          end
        end
        default: begin
          if (!r_sck) begin
            if (!w_hold) r_sck <= 1'b1;
          end else begin
            // End of the high phase: sample, drop SCK, present next value.
            r_sck <= 1'b0;
            case (r_state)
              S_CMD: begin
                if (r_cnt == CMD_LAST) begin
                  r_state  <= S_ADDR;
                  r_cnt    <= '0;
                  r_io_oe  <= 4'b1111;
                  r_io_out <= r_addr[ADDR_BITS-1 -: 4];
                  r_addr   <= r_addr << 4;
                end else begin
                  r_cnt    <= r_cnt + CNT_ONE;
                  r_io_out <= {3'b000, r_cmd[7]};
                  r_cmd    <= r_cmd << 1;
                end
              end
              S_ADDR: begin
                if (r_cnt == ADDR_LAST) begin
                  r_state  <= S_MODE;
                  r_cnt    <= '0;
                  r_io_out <= 4'hF;
                end else begin
                  r_cnt    <= r_cnt + CNT_ONE;
                  r_io_out <= r_addr[ADDR_BITS-1 -: 4];
                  r_addr   <= r_addr << 4;
                end
              end
              S_MODE: begin
                if (r_cnt == MODE_LAST) begin
                  r_state  <= S_DUMMY;
                  r_cnt    <= '0;
                  r_io_oe  <= 4'h0;
                  r_io_out <= 4'h0;
                end else begin
                  r_cnt <= r_cnt + CNT_ONE;
                end
              end
              S_DUMMY: begin
                if (r_cnt == DUMMY_LAST) begin
                  r_state <= S_DATA;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + CNT_ONE;
                end
              end
              S_DATA: begin
                r_acc <= w_acc_next;
                if (r_cnt == '0) r_ready <= 1'b0;
                if (r_cnt == WORD_LAST) begin
                  r_data  <= w_acc_next;
                  r_ready <= 1'b1;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + CNT_ONE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign spi_data_out = r_io_out;
  assign spi_data_oe  = r_io_oe;
  assign spi_select   = r_sel;
  assign spi_clk_out  = r_sck;
  assign data_out     = r_data;
  assign data_ready   = r_ready;
  assign busy         = r_busy;

endmodule

// File: tb/tb_qspi_flash_read_controller.sv
// ---------------------------------------------------------------------------
// tb_qspi_flash_read_controller
// Bench for qspi_flash_read_controller: one DUT with 1-byte words and one with
// 2-byte words, each attached to a behavioural QSPI flash backed by mem[].
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qspi_flash_read_controller;

  logic        clk;
  logic        rstn;
  logic [23:0] addr_in;
  logic        start_read;
  logic        stall_read;
  logic        stop_read;

  logic [7:0]  mem [256];
  int          n_vec;
  int          n_err;
  int          cyc;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DWB = g + 1;
    logic [3:0]       sdi;
    logic [3:0]       sdo;
    logic [3:0]       soe;
    logic             ssel;
    logic             sck;
    logic [8*DWB-1:0] dout;
    logic             drdy;
    logic             dbusy;
    int               edges;
    int               bad_oe;
    logic [7:0]       cmd;
    logic [23:0]      adr;
    logic [7:0]       mode;

    qspi_flash_read_controller #(.DATA_WIDTH_BYTES(DWB), .ADDR_BITS(24)) u_dut (
      .clk(clk), .rstn(rstn),
      .spi_data_in(sdi), .spi_data_out(sdo), .spi_data_oe(soe),
      .spi_select(ssel), .spi_clk_out(sck),
      .addr_in(addr_in), .start_read(start_read),
      .stall_read(stall_read), .stop_read(stop_read),
      .data_out(dout), .data_ready(drdy), .busy(dbusy)
    );

    // Flash: count SCK rises since select fell and decode the header.
    initial begin : capture
      edges = 0; bad_oe = 0; cmd = '0; adr = '0; mode = '0;
      forever begin
        @(posedge sck or posedge ssel);
        if (ssel) begin
          edges = 0;
        end else begin
          edges++;
          if (edges <= 8) begin
            cmd = {cmd[6:0], sdo[0]};
            if (soe !== 4'b0001) bad_oe++;
          end else if (edges <= 14) begin
            adr = {adr[19:0], sdo};
            if (soe !== 4'b1111) bad_oe++;
          end else if (edges <= 16) begin
            mode = {mode[3:0], sdo};
            if (soe !== 4'b1111) bad_oe++;
          end else if (soe !== 4'b0000) begin
            bad_oe++;
          end
        end
      end
    end

    // Flash: after the dummy cycles, put data nibble j out on each SCK fall.
    initial begin : drive
      int         j;
      logic [7:0] b;
      sdi = 4'h0;
      forever begin
        @(negedge sck);
        if (!ssel && edges >= 20) begin
          j   = edges - 20;
          b   = mem[8'(adr + 24'(j / 2))];
          sdi = (j % 2 == 0) ? b[7:4] : b[3:0];
        end
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] exp_byte(input logic [23:0] a, input int k);
    return mem[8'(a + 24'(k))];
  endfunction

  task automatic do_start(input logic [23:0] a, output int c0);
    addr_in    = a;
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    c0         = cyc;
  endtask

  task automatic do_stop();
    stop_read = 1'b1;
    @(negedge clk);
    stop_read = 1'b0;
  endtask

  task automatic wait_rise0(input int limit, output bit ok);
    logic prev;
    prev = g_dut[0].drdy;
    ok   = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (g_dut[0].drdy && !prev) ok = 1'b1;
      prev = g_dut[0].drdy;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({g_dut[0].ssel, g_dut[0].dbusy, g_dut[0].drdy, g_dut[0].sck} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctrl: sel/busy/rdy/sck=%b expected 1000",
               {g_dut[0].ssel, g_dut[0].dbusy, g_dut[0].drdy, g_dut[0].sck});
    end
    n_vec++;
    if ({g_dut[0].soe, g_dut[0].sdo} !== 8'h00) begin
      n_err++; $display("FAIL reset_io: oe/out=%h expected 00", {g_dut[0].soe, g_dut[0].sdo});
    end
    n_vec++;
    if (g_dut[0].dout !== 8'h00) begin
      n_err++; $display("FAIL reset_data: got %h expected 00", g_dut[0].dout);
    end
    n_vec++;
    if ({g_dut[1].ssel, g_dut[1].dbusy, g_dut[1].drdy, g_dut[1].sck, g_dut[1].dout} !== {4'b1000, 16'h0}) begin
      n_err++; $display("FAIL reset_w2: got %b/%h expected 1000/0000",
                        {g_dut[1].ssel, g_dut[1].dbusy, g_dut[1].drdy, g_dut[1].sck}, g_dut[1].dout);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({g_dut[0].ssel, g_dut[0].dbusy} !== 2'b10) begin
      n_err++; $display("FAIL idle_after_reset: sel/busy=%b expected 10", {g_dut[0].ssel, g_dut[0].dbusy});
    end
  endtask

  task automatic test_stream();
    logic [23:0] a;
    int c0, c1, nw;
    bit ok;
    a = 24'h100000;
    mem[8'h00] = 8'hA5;
    mem[8'h01] = 8'h3C;
    do_start(a, c0);
    @(negedge clk);
    n_vec++;
    if ({g_dut[0].ssel, g_dut[0].dbusy, g_dut[0].soe, g_dut[0].sdo} !== {2'b01, 4'b0001, 4'b0001}) begin
      n_err++; $display("FAIL cmd_entry: sel/busy/oe/out=%b expected 0100010001",
                        {g_dut[0].ssel, g_dut[0].dbusy, g_dut[0].soe, g_dut[0].sdo});
    end
    wait_rise0(60, ok);
    n_vec++;
    if (!ok || (cyc - c0) != 45) begin
      n_err++; $display("FAIL first_latency: got %0d clk (seen=%0d) expected 45", cyc - c0, ok);
    end
    n_vec++;
    if (g_dut[0].dout !== 8'hA5) begin
      n_err++; $display("FAIL first_word: got %h expected a5", g_dut[0].dout);
    end
    nw = 3 + $urandom_range(0, 3);
    for (int k = 1; k <= nw; k++) begin
      c1 = cyc;
      wait_rise0(20, ok);
      n_vec++;
      if (!ok || (cyc - c1) != 4) begin
        n_err++; $display("FAIL word_gap: word %0d after %0d clk expected 4", k, cyc - c1);
      end
      n_vec++;
      if (g_dut[0].dout !== exp_byte(a, k)) begin
        n_err++; $display("FAIL stream_word: word %0d got %h expected %h", k, g_dut[0].dout, exp_byte(a, k));
      end
    end
    n_vec++;
    if ({g_dut[0].cmd, g_dut[0].adr, g_dut[0].mode} !== {8'hEB, a, 8'hFF}) begin
      n_err++; $display("FAIL header: cmd/addr/mode=%h/%h/%h expected eb/%h/ff",
                        g_dut[0].cmd, g_dut[0].adr, g_dut[0].mode, a);
    end
    do_stop();
  endtask

  task automatic test_stall();
    logic [23:0] a;
    int c0, c1;
    bit ok;
    a = 24'($urandom);
    stall_read = 1'b1;
    do_start(a, c0);
    wait_rise0(60, ok);
    n_vec++;
    if (!ok || (cyc - c0) != 45 || g_dut[0].dout !== exp_byte(a, 0)) begin
      n_err++; $display("FAIL stall_pre_word: latency %0d data %h expected 45 %h",
                        cyc - c0, g_dut[0].dout, exp_byte(a, 0));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({g_dut[0].sck, g_dut[0].drdy, g_dut[0].ssel} !== 3'b010 || g_dut[0].dout !== exp_byte(a, 0)) begin
        n_err++; $display("FAIL stall_hold: cycle %0d sck/rdy/sel=%b data %h expected 010 %h", i,
                          {g_dut[0].sck, g_dut[0].drdy, g_dut[0].ssel}, g_dut[0].dout, exp_byte(a, 0));
      end
    end
    stall_read = 1'b0;
    wait_rise0(20, ok);
    n_vec++;
    if (!ok || g_dut[0].dout !== exp_byte(a, 1)) begin
      n_err++; $display("FAIL stall_resume: got %h expected %h", g_dut[0].dout, exp_byte(a, 1));
    end
    c1 = cyc;
    wait_rise0(20, ok);
    n_vec++;
    if (!ok || (cyc - c1) != 4 || g_dut[0].dout !== exp_byte(a, 2)) begin
      n_err++; $display("FAIL stall_after: gap %0d data %h expected 4 %h", cyc - c1, g_dut[0].dout, exp_byte(a, 2));
    end
    do_stop();
  endtask

  task automatic test_stop();
    logic [23:0] a;
    int c0;
    bit ok;
    a = 24'($urandom);
    do_start(a, c0);
    wait_rise0(60, ok);
    wait_rise0(20, ok);
    @(negedge clk);
    do_stop();
    n_vec++;
    if ({g_dut[0].ssel, g_dut[0].dbusy, g_dut[0].drdy, g_dut[0].sck, g_dut[0].soe} !== 8'b1000_0000) begin
      n_err++; $display("FAIL stop_ctrl: sel/busy/rdy/sck/oe=%b expected 10000000",
                        {g_dut[0].ssel, g_dut[0].dbusy, g_dut[0].drdy, g_dut[0].sck, g_dut[0].soe});
    end
    n_vec++;
    if (g_dut[0].dout !== exp_byte(a, 1)) begin
      n_err++; $display("FAIL stop_keep: got %h expected %h", g_dut[0].dout, exp_byte(a, 1));
    end
    a = 24'h100010;
    do_start(a, c0);
    wait_rise0(60, ok);
    n_vec++;
    if (!ok || (cyc - c0) != 45 || g_dut[0].dout !== exp_byte(a, 0)) begin
      n_err++; $display("FAIL restart: latency %0d data %h expected 45 %h", cyc - c0, g_dut[0].dout, exp_byte(a, 0));
    end
    addr_in    = 24'($urandom);
    stop_read  = 1'b1;
    start_read = 1'b1;
    @(negedge clk);
    stop_read  = 1'b0;
    start_read = 1'b0;
    n_vec++;
    if ({g_dut[0].ssel, g_dut[0].dbusy} !== 2'b10) begin
      n_err++; $display("FAIL stop_start_same: sel/busy=%b expected 10", {g_dut[0].ssel, g_dut[0].dbusy});
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({g_dut[0].ssel, g_dut[0].dbusy} !== 2'b10) begin
      n_err++; $display("FAIL start_dropped: sel/busy=%b expected 10", {g_dut[0].ssel, g_dut[0].dbusy});
    end
  endtask

  task automatic test_start_while_busy();
    logic [23:0] a;
    int c0;
    bit ok;
    a = 24'($urandom);
    do_start(a, c0);
    wait_rise0(60, ok);
    addr_in    = ~a;
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_rise0(20, ok);
      n_vec++;
      if (!ok || g_dut[0].dout !== exp_byte(a, k) || g_dut[0].ssel !== 1'b0) begin
        n_err++; $display("FAIL busy_start: word %0d got %h sel %b expected %h sel 0",
                          k, g_dut[0].dout, g_dut[0].ssel, exp_byte(a, k));
      end
    end
    do_stop();
  endtask

  task automatic test_width2();
    logic [23:0] a;
    int c0, c1;
    bit ok;
    logic prev;
    a = 24'h100040;
    mem[8'h40] = 8'h11;
    mem[8'h41] = 8'h22;
    do_start(a, c0);
    for (int w = 0; w < 2; w++) begin
      c1   = cyc;
      prev = g_dut[1].drdy;
      ok   = 1'b0;
      for (int i = 0; i < 70 && !ok; i++) begin
        @(negedge clk);
        if (g_dut[1].drdy && !prev) ok = 1'b1;
        prev = g_dut[1].drdy;
      end
      n_vec++;
      if (!ok || (cyc - c1) != ((w == 0) ? 49 : 8)) begin
        n_err++; $display("FAIL w2_timing: word %0d after %0d clk expected %0d", w, cyc - c1, (w == 0) ? 49 : 8);
      end
      n_vec++;
      if (g_dut[1].dout !== {exp_byte(a, 2*w+1), exp_byte(a, 2*w)}) begin
        n_err++; $display("FAIL w2_word: word %0d got %h expected %h", w, g_dut[1].dout,
                          {exp_byte(a, 2*w+1), exp_byte(a, 2*w)});
      end
    end
    do_stop();
  endtask

  task automatic test_reset_abort();
    logic [23:0] a;
    int c0;
    bit ok;
    a = 24'($urandom);
    do_start(a, c0);
    repeat (20 + $urandom_range(0, 40)) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_vec++;
    if ({g_dut[0].ssel, g_dut[0].dbusy, g_dut[0].drdy, g_dut[0].sck, g_dut[0].soe, g_dut[0].dout} !== {8'b1000_0000, 8'h00}) begin
      n_err++; $display("FAIL reset_abort: ctrl %b data %h expected 10000000 00",
                        {g_dut[0].ssel, g_dut[0].dbusy, g_dut[0].drdy, g_dut[0].sck, g_dut[0].soe}, g_dut[0].dout);
    end
    do_start(a, c0);
    wait_rise0(60, ok);
    n_vec++;
    if (!ok || (cyc - c0) != 45 || g_dut[0].dout !== exp_byte(a, 0)) begin
      n_err++; $display("FAIL reset_recover: latency %0d data %h expected 45 %h", cyc - c0, g_dut[0].dout, exp_byte(a, 0));
    end
    do_stop();
    n_vec++;
    if (g_dut[0].bad_oe != 0 || g_dut[1].bad_oe != 0) begin
      n_err++; $display("FAIL oe_phases: %0d/%0d wrong enables expected 0", g_dut[0].bad_oe, g_dut[1].bad_oe);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rstn       = 1'b0;
    addr_in    = '0;
    start_read = 1'b0;
    stall_read = 1'b0;
    stop_read  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_stream();
    test_stall();
    test_stop();
    test_start_while_busy();
    test_width2();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
